cdb_arbiter: RTL and testbench

- Transmitter side of the common data bus. Collects completed results from the functional units and broadcasts one result per cycle as (valid, ROB tag, value).
- Broadcasts are consumed by the reservation stations, map table and ROB.
- Each FU gets a one-entry holding buffer with a ready handshake, so an FU finishing while another owns the bus stalls rather than losing its result.
- Round-robin arbitration keeps long-latency FP/Load units from being starved by the ALU.

---
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: transmitter side of the common data bus.
//
// Each functional unit owns a one-entry holding buffer. A round-robin arbiter
// picks one valid buffer per cycle and drives its (tag, value) onto the bus,
// which reservation stations, map table and ROB consume.
//
// Ports:
//   clock, reset   system clock; asynchronous active-high reset
//   flush          synchronous squash of every buffered and in-flight result
//   fu_done        per-FU "result available" strobe
//   fu_rob_tag     per-FU ROB tag, slice [i*TAG_W +: TAG_W]
//   fu_value       per-FU result value, slice [i*XLEN +: XLEN]
//   fu_ready       per-FU "buffer can take a result this cycle"
//   cdb_valid      broadcast valid
//   cdb_rob_tag    broadcast tag, forced to 0 when the bus is idle
//   cdb_value      broadcast value, forced to 0 when the bus is idle
//   cdb_fu_idx     which FU the current broadcast came from

module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32,
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_FU-1:0]         fu_done,
    input  logic [NUM_FU*TAG_W-1:0]   fu_rob_tag,
    input  logic [NUM_FU*XLEN-1:0]    fu_value,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_rob_tag,
    output logic [XLEN-1:0]           cdb_value,
    output logic [IDX_W-1:0]          cdb_fu_idx
);

    logic [NUM_FU-1:0] buf_valid;
    logic [TAG_W-1:0]  buf_tag   [NUM_FU];
    logic [XLEN-1:0]   buf_value [NUM_FU];
    logic [IDX_W-1:0]  rr_ptr;

    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic [NUM_FU-1:0] grant;
    logic [IDX_W-1:0]  next_ptr;
    logic [NUM_FU-1:0] accept;
    int                cand;
    logic [IDX_W-1:0]  cand_idx;

    // Round-robin pick: first valid buffer at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_FU) begin
                cand = cand - NUM_FU;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!grant_any && buf_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign next_ptr = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Ready comes only from registered state and the arbiter: a buffer being
    // drained this cycle can be refilled in the same cycle, which is what lets
    // a lone FU stream back-to-back.
    assign fu_ready = ~buf_valid | grant;
    assign accept   = fu_done & fu_ready;

    // Buffers, round-robin pointer and the registered bus outputs. Flush beats
    // both acceptance and grant; a tag-0 result completes its handshake but is
    // dropped since nothing downstream may ever see a real broadcast of tag 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid   <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                buf_tag[i]   <= '0;
                buf_value[i] <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_value   <= '0;
            cdb_fu_idx  <= '0;
        end else if (flush) begin
            buf_valid   <= '0;
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_value   <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i] && (fu_rob_tag[i*TAG_W +: TAG_W] != '0)) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= fu_rob_tag[i*TAG_W +: TAG_W];
                    buf_value[i] <= fu_value[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                cdb_valid   <= 1'b1;
                cdb_rob_tag <= buf_tag[grant_idx];
                cdb_value   <= buf_value[grant_idx];
                cdb_fu_idx  <= grant_idx;
                rr_ptr      <= next_ptr;
            end else begin
                cdb_valid   <= 1'b0;
                cdb_rob_tag <= '0;
                cdb_value   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: self-checking bench for cdb_arbiter.
// Directed vector table, hand-written corner sequences, then randomized
// traffic checked against a small behavioural model of the bus.

module tb_cdb_arbiter;

    localparam int N = 5;

    logic          clock;
    logic          reset;
    logic          flush;
    logic [4:0]    fu_done;
    logic [24:0]   fu_rob_tag;
    logic [159:0]  fu_value;
    logic [4:0]    fu_ready;
    logic          cdb_valid;
    logic [4:0]    cdb_rob_tag;
    logic [31:0]   cdb_value;
    logic [2:0]    cdb_fu_idx;

    int n_checks;
    int n_fail;

    cdb_arbiter #(.NUM_FU(5), .TAG_W(5), .XLEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .fu_done    (fu_done),
        .fu_rob_tag (fu_rob_tag),
        .fu_value   (fu_value),
        .fu_ready   (fu_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_tag(cdb_rob_tag),
        .cdb_value  (cdb_value),
        .cdb_fu_idx (cdb_fu_idx)
    );

    // 10-unit clock period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop if something never returns
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural model: buffers as plain arrays, pointer as an integer
    bit          m_bv   [N];
    logic [4:0]  m_tag  [N];
    logic [31:0] m_val  [N];
    int          m_ptr;
    logic        m_cv;
    logic [4:0]  m_ct;
    logic [31:0] m_cval;
    int          m_idx;

    function automatic int modelWinner();
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (m_bv[k]) return k;
        end
        return -1;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            m_bv[i]  = 1'b0;
            m_tag[i] = '0;
            m_val[i] = '0;
        end
        m_ptr  = 0;
        m_cv   = 1'b0;
        m_ct   = '0;
        m_cval = '0;
        m_idx  = 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] done, input logic [24:0] tags,
                                 input logic [31:0] base, input logic fl);
        fu_done    = done;
        fu_rob_tag = tags;
        for (int i = 0; i < N; i++) begin
            fu_value[i*32 +: 32] = base + 32'(i);
        end
        flush = fl;
    endtask

    // One clock: check ready against the model, advance the model with the
    // current inputs, take the edge, compare the bus.
    task automatic runCycle(output logic [4:0] acc);
        int         w;
        logic [4:0] rdy;
        w = modelWinner();
        for (int i = 0; i < N; i++) begin
            rdy[i] = !m_bv[i] || (w == i);
        end
        checkOutput("model_ready", 32'(fu_ready), 32'(rdy));
        acc = fu_done & rdy;
        if (flush) begin
            for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
            m_cv   = 1'b0;
            m_ct   = '0;
            m_cval = '0;
        end else begin
            if (w >= 0) begin
                m_cv    = 1'b1;
                m_ct    = m_tag[w];
                m_cval  = m_val[w];
                m_idx   = w;
                m_bv[w] = 1'b0;
                m_ptr   = (w + 1) % N;
            end else begin
                m_cv   = 1'b0;
                m_ct   = '0;
                m_cval = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i] && fu_rob_tag[i*5 +: 5] != 5'd0) begin
                    m_bv[i]  = 1'b1;
                    m_tag[i] = fu_rob_tag[i*5 +: 5];
                    m_val[i] = fu_value[i*32 +: 32];
                end
            end
        end
        @(posedge clock);
        #1;
        checkOutput("model_cdb_valid", 32'(cdb_valid), 32'(m_cv));
        checkOutput("model_cdb_tag", 32'(cdb_rob_tag), 32'(m_ct));
        checkOutput("model_cdb_value", cdb_value, m_cval);
        checkOutput("model_cdb_fu_idx", 32'(cdb_fu_idx), 32'(m_idx));
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        checkOutput("reset_cdb_tag", 32'(cdb_rob_tag), 32'd0);
        checkOutput("reset_cdb_value", cdb_value, 32'd0);
        checkOutput("reset_cdb_fu_idx", 32'(cdb_fu_idx), 32'd0);
        checkOutput("reset_ready", 32'(fu_ready), 32'h1f);
    endtask

    typedef struct {
        logic        rst;
        logic [4:0]  done;
        logic [24:0] tags;
        logic [31:0] base;
        logic        exp_valid;
        logic [4:0]  exp_tag;
        logic [31:0] exp_value;
        logic [2:0]  exp_idx;
        logic [4:0]  exp_ready;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic rst, logic [4:0] done, logic [24:0] tags, logic [31:0] base,
                                logic ev, logic [4:0] et, logic [31:0] eval, logic [2:0] ei,
                                logic [4:0] er);
        vec_t v;
        v.rst = rst; v.done = done; v.tags = tags; v.base = base;
        v.exp_valid = ev; v.exp_tag = et; v.exp_value = eval; v.exp_idx = ei; v.exp_ready = er;
        return v;
    endfunction

    initial begin
        logic [4:0] acc;
        logic [4:0] pend;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b0);

        // Idle after reset, single FU0 result, then all five at once with a
        // second FU0 result held off until FU0's buffer drains.
        vecs.push_back(mk(1, 5'b00000, 25'd0, 32'h0, 0, 5'd0, 32'h0, 3'd0, 5'b11111));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 5'b00000, 25'd0, 32'h0, 0, 5'd0, 32'h0, 3'd0, 5'b11111));
        vecs.push_back(mk(0, 5'b00001, 25'd3, 32'hDEAD, 0, 5'd0, 32'h0, 3'd0, 5'b11111));
        vecs.push_back(mk(0, 5'b00000, 25'd0, 32'h0, 1, 5'd3, 32'hDEAD, 3'd0, 5'b11111));
        vecs.push_back(mk(0, 5'b00000, 25'd0, 32'h0, 0, 5'd0, 32'h0, 3'd0, 5'b11111));
        vecs.push_back(mk(1, 5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 32'h5000,
                          0, 5'd0, 32'h0, 3'd0, 5'b00001));
        vecs.push_back(mk(0, 5'b00001, 25'd6, 32'h6000, 1, 5'd1, 32'h5000, 3'd0, 5'b00010));
        vecs.push_back(mk(0, 5'b00001, 25'd7, 32'h7000, 1, 5'd2, 32'h5001, 3'd1, 5'b00110));
        vecs.push_back(mk(0, 5'b00001, 25'd7, 32'h7000, 1, 5'd3, 32'h5002, 3'd2, 5'b01110));
        vecs.push_back(mk(0, 5'b00001, 25'd7, 32'h7000, 1, 5'd4, 32'h5003, 3'd3, 5'b11110));
        vecs.push_back(mk(0, 5'b00001, 25'd7, 32'h7000, 1, 5'd5, 32'h5004, 3'd4, 5'b11111));
        vecs.push_back(mk(0, 5'b00001, 25'd7, 32'h7000, 1, 5'd6, 32'h6000, 3'd0, 5'b11111));
        vecs.push_back(mk(0, 5'b00000, 25'd0, 32'h0, 1, 5'd7, 32'h7000, 3'd0, 5'b11111));
        vecs.push_back(mk(0, 5'b00000, 25'd0, 32'h0, 0, 5'd0, 32'h0, 3'd0, 5'b11111));

        foreach (vecs[k]) begin
            if (vecs[k].rst) doReset();
            applyStimulus(vecs[k].done, vecs[k].tags, vecs[k].base, 1'b0);
            @(posedge clock);
            #1;
            checkOutput($sformatf("vec%0d_valid", k), 32'(cdb_valid), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d_tag", k), 32'(cdb_rob_tag), 32'(vecs[k].exp_tag));
            checkOutput($sformatf("vec%0d_value", k), cdb_value, vecs[k].exp_value);
            if (vecs[k].exp_valid)
                checkOutput($sformatf("vec%0d_fu_idx", k), 32'(cdb_fu_idx), 32'(vecs[k].exp_idx));
            checkOutput($sformatf("vec%0d_ready", k), 32'(fu_ready), 32'(vecs[k].exp_ready));
        end

        // FU0 streams tags 1..8 alone: no bubbles, ready never drops
        doReset();
        for (int t = 1; t <= 8; t++) begin
            applyStimulus(5'b00001, 25'(t), 32'h100 + 32'(t), 1'b0);
            checkOutput("stream_ready0", 32'(fu_ready[0]), 32'd1);
            runCycle(acc);
            if (t >= 2) begin
                checkOutput("stream_valid", 32'(cdb_valid), 32'd1);
                checkOutput("stream_tag", 32'(cdb_rob_tag), 32'(t - 1));
            end
        end
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b0);
        runCycle(acc);
        checkOutput("stream_last_tag", 32'(cdb_rob_tag), 32'd8);
        runCycle(acc);
        checkOutput("stream_idle_valid", 32'(cdb_valid), 32'd0);

        // Flush before FU2's grant: tag 7 never broadcast
        doReset();
        applyStimulus(5'b00100, 25'(7) << 10, 32'h700, 1'b0);
        runCycle(acc);
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b1);
        runCycle(acc);
        checkOutput("flush_valid", 32'(cdb_valid), 32'd0);
        checkOutput("flush_tag", 32'(cdb_rob_tag), 32'd0);
        checkOutput("flush_ready2", 32'(fu_ready[2]), 32'd1);
        // Result accepted in a flush cycle is discarded
        applyStimulus(5'b00010, 25'(9) << 5, 32'h900, 1'b1);
        runCycle(acc);
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b0);
        runCycle(acc);
        checkOutput("flush_accept_valid", 32'(cdb_valid), 32'd0);
        runCycle(acc);
        checkOutput("flush_accept_valid2", 32'(cdb_valid), 32'd0);

        // Tag 0 completes the handshake but is never broadcast
        applyStimulus(5'b00010, 25'd0, 32'h1234, 1'b0);
        checkOutput("tag0_ready1", 32'(fu_ready[1]), 32'd1);
        runCycle(acc);
        checkOutput("tag0_accepted", 32'(acc[1]), 32'd1);
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b0);
        runCycle(acc);
        checkOutput("tag0_no_bcast", 32'(cdb_valid), 32'd0);
        checkOutput("tag0_ready_all", 32'(fu_ready), 32'h1f);

        // Async reset with three buffers still waiting
        applyStimulus(5'b01111, {5'd0, 5'd13, 5'd12, 5'd11, 5'd10}, 32'hA00, 1'b0);
        runCycle(acc);
        applyStimulus(5'b0, 25'b0, 32'b0, 1'b0);
        runCycle(acc);
        checkOutput("preasync_valid", 32'(cdb_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(cdb_valid), 32'd0);
        checkOutput("async_tag", 32'(cdb_rob_tag), 32'd0);
        checkOutput("async_value", cdb_value, 32'd0);
        checkOutput("async_ready", 32'(fu_ready), 32'h1f);
        @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        for (int c = 0; c < 6; c++) begin
            runCycle(acc);
            checkOutput("post_async_valid", 32'(cdb_valid), 32'd0);
        end

        // Randomized traffic against the model
        doReset();
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    fu_rob_tag[i*5 +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    fu_value[i*32 +: 32] = $urandom;
                end
            end
            fu_done = pend;
            flush   = ($urandom_range(0, 39) == 0);
            runCycle(acc);
            pend = pend & ~acc;
        end
        fu_done = '0;
        flush   = 1'b0;
        for (int c = 0; c < 10; c++) runCycle(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
